// File: rtl/alu_pipe_if.sv
// Handshake and condition-code bundle for alu_pipe: operation in, result out, live CC flags.
interface alu_pipe_if #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_set_cc;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;
   logic             cc_zf;
   logic             cc_sf;
   logic             cc_of;

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_set_cc, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_err, cc_zf, cc_sf, cc_of
   );

   modport master (
      output in_valid, in_op, in_a, in_b, in_set_cc, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_err, cc_zf, cc_sf, cc_of
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined Y86-64 execute ALU with valid/ready backpressure and in-order CC register.
// Define ALU_EXT_OPS_EN to enable ops 4..7 (OR, SHL, SHR, SAR); otherwise they retire as errors.
module alu_pipe #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_pipe_if.slave  bus
);
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;

   logic             stall;
   logic             retire;

   logic             s1_valid;
   logic [2:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_set_cc;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_result;
   logic [TAG_W-1:0] s2_tag;
   logic             s2_err;
   logic             s2_set_cc;
   logic             s2_zf;
   logic             s2_sf;
   logic             s2_of;

   logic             cc_zf_reg;
   logic             cc_sf_reg;
   logic             cc_of_reg;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] result_next;
   logic             of_next;
   logic             err_next;

   // One stall signal freezes both stages, so no skid buffer is needed.
   assign stall        = s2_valid && !bus.out_ready;
   assign retire       = s2_valid && bus.out_ready;
   assign bus.in_ready = !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_op     <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_set_cc <= 1'b0;
         s1_tag    <= '0;
      end else if (!stall) begin
         s1_valid  <= bus.in_valid;
         s1_op     <= bus.in_op;
         s1_a      <= bus.in_a;
         s1_b      <= bus.in_b;
         s1_set_cc <= bus.in_set_cc;
         s1_tag    <= bus.in_tag;
      end
   end

   // Y86 convention: the result is B op A (subq computes valB - valA).
   assign sum  = s1_b + s1_a;
   assign diff = s1_b - s1_a;

`ifdef ALU_EXT_OPS_EN
   localparam int SHAMT_W = $clog2(WIDTH);
   logic [SHAMT_W-1:0] shamt;
   assign shamt = s1_a[SHAMT_W-1:0];
`endif

   always_comb begin
      result_next = '0;
      of_next     = 1'b0;
      err_next    = 1'b0;
      case (s1_op)
         OP_ADD: begin
            result_next = sum;
            of_next     = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_SUB: begin
            result_next = diff;
            of_next     = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_b[WIDTH-1]);
         end
         OP_AND: result_next = s1_b & s1_a;
         OP_XOR: result_next = s1_b ^ s1_a;
`ifdef ALU_EXT_OPS_EN
         3'd4:   result_next = s1_b | s1_a;
         3'd5:   result_next = s1_b << shamt;
         3'd6:   result_next = s1_b >> shamt;
         default: result_next = $unsigned($signed(s1_b) >>> shamt);
`else
         default: err_next = 1'b1;
`endif
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_tag    <= '0;
         s2_err    <= 1'b0;
         s2_set_cc <= 1'b0;
         s2_zf     <= 1'b0;
         s2_sf     <= 1'b0;
         s2_of     <= 1'b0;
      end else if (!stall) begin
         s2_valid  <= s1_valid;
         s2_result <= result_next;
         s2_tag    <= s1_tag;
         s2_err    <= err_next;
         s2_set_cc <= s1_set_cc;
         s2_zf     <= (result_next == '0);
         s2_sf     <= result_next[WIDTH-1];
         s2_of     <= of_next;
      end
   end

   // CC follows retirement, not computation, so a stalled result never updates it early.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_zf_reg <= 1'b1;
         cc_sf_reg <= 1'b0;
         cc_of_reg <= 1'b0;
      end else if (retire && s2_set_cc && !s2_err) begin
         cc_zf_reg <= s2_zf;
         cc_sf_reg <= s2_sf;
         cc_of_reg <= s2_of;
      end
   end

   assign bus.out_valid  = s2_valid;
   assign bus.out_result = s2_result;
   assign bus.out_tag    = s2_tag;
   assign bus.out_err    = s2_err;
   assign bus.cc_zf      = cc_zf_reg;
   assign bus.cc_sf      = cc_sf_reg;
   assign bus.cc_of      = cc_of_reg;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table plus scoreboard, stall and reset sequences.
module tb_alu_pipe;
   localparam int WIDTH = 64;
   localparam int TAG_W = 4;
`ifdef ALU_EXT_OPS_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   typedef struct {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sc;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] er;
      logic             ee;
      logic             eo;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] r;
      logic [TAG_W-1:0] tag;
      logic             err;
      logic             sc;
      logic             of;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
   exp_t sb[$];
   int   retire_cycles[$];
   vec_t vecs[10];

   alu_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
   alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard and CC model: CC changes become visible one cycle after a retiring edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("cc", {61'd0, bus.cc_zf, bus.cc_sf, bus.cc_of}, {61'd0, m_zf, m_sf, m_of});
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", {63'd0, bus.out_valid}, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", bus.out_result, e.r);
               chk("tag", {60'd0, bus.out_tag}, {60'd0, e.tag});
               chk("err", {63'd0, bus.out_err}, {63'd0, e.err});
               $display("retire tag=%0d result=%h err=%0d", bus.out_tag, bus.out_result, bus.out_err);
               if (e.sc && !e.err) begin
                  m_zf = (e.r == '0);
                  m_sf = e.r[WIDTH-1];
                  m_of = e.of;
               end
            end
            retire_cycles.push_back(cyc);
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sc, input logic [TAG_W-1:0] tag,
                       input logic [WIDTH-1:0] er, input logic ee, input logic eo);
      bit ok;
      exp_t e;
      ok = 1'b0;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
      bus.in_set_cc = sc; bus.in_tag = tag;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         chk("accept_timeout", 64'd0, 64'd1);
      end else begin
         e.r = er; e.tag = tag; e.err = ee; e.sc = sc; e.of = eo;
         sb.push_back(e);
         $display("send op=%0d a=%h b=%h tag=%0d", op, a, b, tag);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) chk("drain_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0] = '{3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd5, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[1] = '{3'd1, 64'd3, 64'd3, 1'b1, 4'd1, 64'd0, 1'b0, 1'b0};
      vecs[2] = '{3'd1, 64'd1, 64'd0, 1'b0, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[3] = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd3, 64'd0, 1'b0, 1'b0};
      vecs[4] = '{3'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 4'd4, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
      vecs[5] = '{3'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 4'd6,
                  64'hF000_F000_F000_F000, 1'b0, 1'b0};
      vecs[6] = '{3'd5, 64'd4, 64'd1, 1'b1, 4'd7, EXT ? 64'h10 : 64'd0, !EXT, 1'b0};
      vecs[7] = '{3'd4, 64'h0F, 64'hF0, 1'b1, 4'd8, EXT ? 64'hFF : 64'd0, !EXT, 1'b0};
      vecs[8] = '{3'd6, 64'h44, 64'h8000_0000_0000_0000, 1'b1, 4'd9,
                  EXT ? 64'h0800_0000_0000_0000 : 64'd0, !EXT, 1'b0};
      vecs[9] = '{3'd7, 64'd4, 64'h8000_0000_0000_0000, 1'b1, 4'd10,
                  EXT ? 64'hF800_0000_0000_0000 : 64'd0, !EXT, 1'b0};

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
      bus.in_set_cc = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("reset_out_result", bus.out_result, 64'd0);
      chk("reset_out_err", {63'd0, bus.out_err}, 64'd0);
      chk("reset_cc", {61'd0, bus.cc_zf, bus.cc_sf, bus.cc_of}, 64'd4);
      @(posedge clk); #1;

      // Vector table, issued back to back.
      foreach (vecs[i])
         send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sc, vecs[i].tag, vecs[i].er, vecs[i].ee, vecs[i].eo);
      idle();
      drain();

      // Eight back-to-back XORs must retire on eight consecutive cycles.
      retire_cycles.delete();
      for (int i = 0; i < 8; i++) begin
         logic [WIDTH-1:0] a, b;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         send(3'd3, a, b, 1'(i % 2), 4'(i), a ^ b, 1'b0, 1'b0);
      end
      idle();
      drain();
      chk("stream_count", 64'(retire_cycles.size()), 64'd8);
      for (int i = 1; i < retire_cycles.size(); i++)
         chk("stream_consecutive", 64'(retire_cycles[i] - retire_cycles[i-1]), 64'd1);

      // Backpressure with two ops in flight.
      bus.out_ready = 1'b0;
      send(3'd0, 64'd10, 64'd20, 1'b1, 4'd11, 64'd30, 1'b0, 1'b0);
      send(3'd1, 64'd5, 64'd2, 1'b1, 4'd12, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
         chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("stall_result", bus.out_result, 64'd30);
         chk("stall_tag", {60'd0, bus.out_tag}, 64'd11);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drain();

      // Put CC in a non-reset state, then reset with two set_cc ops in flight.
      send(3'd0, 64'd0, 64'h8000_0000_0000_0000, 1'b1, 4'd13, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
      idle();
      drain();
      bus.out_ready = 1'b0;
      send(3'd0, 64'd1, 64'd1, 1'b1, 4'd14, 64'd2, 1'b0, 1'b0);
      send(3'd1, 64'd1, 64'd0, 1'b1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      sb.delete();
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("post_reset_cc", {61'd0, bus.cc_zf, bus.cc_sf, bus.cc_of}, 64'd4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_reset_no_stale", {63'd0, bus.out_valid}, 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined integer ALU for the Y86-64 pipeline's execute stage; successor to the single-cycle combinational ALU.
- Adds valid/ready handshake with backpressure, a tag passthrough, and a condition-code register (ZF/SF/OF) updated in order as results retire.
- Sits between decode/execute pipeline registers and the memory stage; cc_* outputs feed the branch/cmov condition logic.

Parameters:
- WIDTH, 64, operand/result width in bits (>= 8).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept the operation this cycle.
- in_op  in  3  0=ADD, 1=SUB, 2=AND, 3=XOR; 4..7 per Optional Feature.
- in_a  in  WIDTH  operand A (valA).
- in_b  in  WIDTH  operand B (valB).
- in_set_cc  in  1  this operation updates the CC register when it retires.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result (valE).
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  opcode was illegal in this build.
- cc_zf, cc_sf, cc_of  out  1 each  architectural condition codes.

Behaviour:
- Reset (async assert, sync-safe deassert): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0, out_err=0, cc_zf=1, cc_sf=0, cc_of=0. in_ready=1 after reset. Reset mid-operation discards all in-flight operations; the CC register is not updated by them.
- Stage 1 registers op/a/b/set_cc/tag. Stage 2 computes and registers the result, flags, and error. Latency is exactly 2 cycles from accept to out_valid when there is no stall.
- Handshake: accept when in_valid && in_ready; retire when out_valid && out_ready.
- Global stall: stall = s2_valid && !out_ready; in_ready = !stall. While stalled, both stages hold all contents. A bubble in s1 still advances into s2 when not stalled. Full throughput is 1 op/cycle.
- Arithmetic is in WIDTH bits, two's complement, with wrap-around.
  - ADD: R = B + A; OF = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB: R = B - A, per Y86 subq; OF = (A[msb]!=B[msb]) && (R[msb]!=B[msb]).
  - AND, XOR: bitwise; OF = 0.
- Flags: ZF = (R==0), SF = R[msb]. They are computed in stage 2 and held with the result.
- CC register: loads ZF/SF/OF on the cycle a result retires with set_cc=1 and err=0. Otherwise it holds. The update is visible on cc_* the cycle after retirement. Ordering follows retirement order.
- Illegal op: R=0, flags not applied, out_err=1 with the result. The result is still retired normally.
- out_* must be stable while out_valid && !out_ready.

Optional Feature:
- Macro ALU_EXT_OPS_EN.
- Defined: ops 4=OR, 5=SHL (B << A[log2(WIDTH)-1:0]), 6=SHR logical, 7=SAR arithmetic. The shift amount uses the low log2(WIDTH) bits of A. OF=0 for all four. ZF/SF follow the normal rules.
- Not defined: ops 4..7 are illegal (R=0, out_err=1, no CC update). No shifter logic is synthesised.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, cc_zf=1, cc_sf=0, cc_of=0.
- ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1, set_cc=1, tag=5 -> 2 cycles later out_result=0x8000_0000_0000_0000, out_tag=5; after retirement cc_of=1, cc_sf=1, cc_zf=0.
- SUB A=3, B=3, set_cc=1 -> result 0, ZF=1 after retirement. A second op SUB A=1, B=0 with set_cc=0 -> result 0xFFFF_FFFF_FFFF_FFFF; CC stays ZF=1.
- Back-to-back stream of 8 XORs with out_ready=1 -> 8 consecutive out_valid cycles, correct tags in order. Then hold out_ready=0 for 3 cycles with 2 ops in flight -> in_ready=0, outputs stable, no loss or duplication after release.
- Op 5 with A=4, B=1 -> with ALU_EXT_OPS_EN: result 0x10, out_err=0. Without it: result 0, out_err=1, CC unchanged.
- Assert rst_n low while 2 ops in flight with set_cc=1 -> out_valid=0 immediately; after release, CC = reset values and no stale result appears.
